// File: rtl/us_tx_pkg.sv
// Shared types and defaults for the ultrasound transmit pulser.
// States, default widths and synchroniser depth.
package us_tx_pkg;

  localparam int CNT_W       = 16;
  localparam int NP_W        = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POS,
    S_DEAD_A,
    S_NEG,
    S_DEAD_B,
    S_DAMP,
    S_FIN
  } us_tx_state_t;

endpackage

// File: rtl/us_lock_qual.sv
// PLL lock qualifier: synchroniser plus stability counter.
// ready_o asserts after LOCK_STABLE consecutive synced-lock cycles.
module us_lock_qual #(
  parameter int LOCK_STABLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_i,
  output logic lock_ok_o,
  output logic ready_o
);
  import us_tx_pkg::*;

  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam logic [LW-1:0] LIM = LW'(LOCK_STABLE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [LW-1:0]          cnt_q;
  logic [LW-1:0]          cnt_d;

  assign lock_ok_o = sync_q[SYNC_STAGES-1];
  assign ready_o   = (cnt_q == LIM);

  // Saturating count of consecutive synced-lock cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (!lock_ok_o)
      cnt_d = '0;
    else if (cnt_q != LIM)
      cnt_d = cnt_q + 1'b1;
  end

  // Synchroniser and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/us_tx_pulser.sv
// Bipolar ultrasound burst generator with dead time and lock abort.
// Define US_TX_DAMP_EN to build the post-burst damping interval.
module us_tx_pulser #(
  parameter int CNT_W       = us_tx_pkg::CNT_W,
  parameter int NP_W        = us_tx_pkg::NP_W,
  parameter int LOCK_STABLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             start,
  input  logic [NP_W-1:0]  num_pulses,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] dead_time,
  input  logic [CNT_W-1:0] damp_len,
  output logic             tx_p,
  output logic             tx_n,
  output logic             damp,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             lock_err
);
  import us_tx_pkg::*;

  us_tx_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic [NP_W-1:0]  pc_q, pc_d;
  logic             lock_err_d;
  logic             lock_ok;
  logic             tx_p_q, tx_n_q, busy_q, done_q, lerr_q;

  us_lock_qual #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock (
    .clk      (clk),
    .rst      (rst),
    .lock_i   (pll_locked),
    .lock_ok_o(lock_ok),
    .ready_o  (ready)
  );

`ifdef US_TX_DAMP_EN
  logic [CNT_W-1:0] dl_q, dl_d;
  logic             damp_q;
  assign damp = damp_q;
`else
  logic unused_damp_len;
  assign unused_damp_len = ^damp_len;
  assign damp = 1'b0;
`endif

  assign tx_p     = tx_p_q;
  assign tx_n     = tx_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign lock_err = lerr_q;

  // Next-state, phase counters and latched burst parameters.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    h_d        = h_q;
    d_d        = d_q;
    pc_d       = pc_q;
    lock_err_d = lerr_q;
`ifdef US_TX_DAMP_EN
    dl_d       = dl_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && ready) begin
          h_d        = (half_period == '0) ? CNT_W'(1) : half_period;
          d_d        = dead_time;
          pc_d       = num_pulses - 1'b1;
          lock_err_d = 1'b0;
`ifdef US_TX_DAMP_EN
          dl_d       = damp_len;
`endif
          if (num_pulses == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_POS;
            cnt_d   = h_d - 1'b1;
          end
        end
      end
      S_POS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (d_q != '0) begin
          state_d = S_DEAD_A;
          cnt_d   = d_q - 1'b1;
        end else begin
          state_d = S_NEG;
          cnt_d   = h_q - 1'b1;
        end
      end
      S_DEAD_A: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_NEG;
          cnt_d   = h_q - 1'b1;
        end
      end
      S_NEG: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pc_q != '0) begin
          pc_d = pc_q - 1'b1;
          if (d_q != '0) begin
            state_d = S_DEAD_B;
            cnt_d   = d_q - 1'b1;
          end else begin
            state_d = S_POS;
            cnt_d   = h_q - 1'b1;
          end
        end else begin
`ifdef US_TX_DAMP_EN
          if (dl_q != '0) begin
            state_d = S_DAMP;
            cnt_d   = dl_q - 1'b1;
          end else begin
            state_d = S_FIN;
          end
`else
          state_d = S_FIN;
`endif
        end
      end
      S_DEAD_B: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_POS;
          cnt_d   = h_q - 1'b1;
        end
      end
`ifdef US_TX_DAMP_EN
      S_DAMP: begin
        if (cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
        else
          state_d = S_FIN;
      end
`endif
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Loss of lock mid-burst kills the drive and still reports done.
    if (!lock_ok && state_q != S_IDLE && state_q != S_FIN) begin
      state_d    = S_FIN;
      lock_err_d = 1'b1;
    end
  end

  // State, counters and registered outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
      tx_p_q  <= 1'b0;
      tx_n_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
`ifdef US_TX_DAMP_EN
      dl_q    <= '0;
      damp_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      tx_p_q  <= (state_d == S_POS);
      tx_n_q  <= (state_d == S_NEG);
      busy_q  <= (state_d != S_IDLE) && (state_d != S_FIN);
      done_q  <= (state_d == S_FIN);
      lerr_q  <= lock_err_d;
`ifdef US_TX_DAMP_EN
      dl_q    <= dl_d;
      damp_q  <= (state_d == S_DAMP);
`endif
    end
  end

endmodule

// File: tb/tb_us_tx_pulser.sv
// Directed bench for us_tx_pulser: vector table plus corner sequences.
// Expectations follow US_TX_DAMP_EN when it is defined.
`timescale 1ns/1ps
module tb_us_tx_pulser;

  localparam int LS = 16;
  localparam int WIN = 40;
`ifdef US_TX_DAMP_EN
  localparam bit DAMP_ON = 1'b1;
`else
  localparam bit DAMP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        start;
  logic [7:0]  num_pulses;
  logic [15:0] half_period;
  logic [15:0] dead_time;
  logic [15:0] damp_len;
  logic        tx_p, tx_n, damp, ready, busy, done, lock_err;

  int n_cmp = 0;
  int n_bad = 0;

  us_tx_pulser #(
    .CNT_W(16),
    .NP_W(8),
    .LOCK_STABLE(LS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .start      (start),
    .num_pulses (num_pulses),
    .half_period(half_period),
    .dead_time  (dead_time),
    .damp_len   (damp_len),
    .tx_p       (tx_p),
    .tx_n       (tx_n),
    .damp       (damp),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .lock_err   (lock_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]     np;
    logic [15:0]    hp;
    logic [15:0]    dt;
    logic [15:0]    dl;
    logic [WIN-1:0] p;
    logic [WIN-1:0] n;
    logic [WIN-1:0] d;
    logic [WIN-1:0] dn;
    logic [WIN-1:0] bz;
  } vec_t;

  vec_t tv[6];

  // Drive invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    n_cmp++;
    if ((tx_p && tx_n) || (damp && (tx_p || tx_n)) ||
        (!busy && (tx_p || tx_n || damp))) begin
      n_bad++;
      $display("FAIL invariant @%0t: p=%b n=%b damp=%b busy=%b req exclusive",
               $time, tx_p, tx_n, damp, busy);
    end
  end

  function automatic logic [WIN-1:0] rng(int lo, int hi);
    logic [WIN-1:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input vec_t v, input int xs1, input int xs2,
                           output logic [WIN-1:0] gp, output logic [WIN-1:0] gn,
                           output logic [WIN-1:0] gd, output logic [WIN-1:0] gdn,
                           output logic [WIN-1:0] gb);
    gp = '0; gn = '0; gd = '0; gdn = '0; gb = '0;
    num_pulses  = v.np;
    half_period = v.hp;
    dead_time   = v.dt;
    damp_len    = v.dl;
    for (int c = 0; c < WIN; c++) begin
      gp[c]  = tx_p;
      gn[c]  = tx_n;
      gd[c]  = damp;
      gdn[c] = done;
      gb[c]  = busy;
      start  = (c == 0) || (c == xs1) || (c == xs2);
      cyc();
    end
    start = 1'b0;
  endtask

  task automatic wait_ready(input int st_at, output int k, output bit saw_busy);
    k = -1;
    saw_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      start = (i == st_at);
      if (busy) saw_busy = 1'b1;
      cyc();
      if (k < 0 && ready) k = i + 1;
    end
    start = 1'b0;
  endtask

  logic [WIN-1:0] gp, gn, gd, gdn, gb;
  int  k;
  bit  sb;
  int  dcyc;

  initial begin
    tv[0] = '{8'd2, 16'd3, 16'd1, 16'd4,
              rng(1,3) | rng(9,11), rng(5,7) | rng(13,15),
              DAMP_ON ? rng(16,19) : '0,
              DAMP_ON ? rng(20,20) : rng(16,16),
              DAMP_ON ? rng(1,19) : rng(1,15)};
    tv[1] = '{8'd2, 16'd3, 16'd0, 16'd0,
              rng(1,3) | rng(7,9), rng(4,6) | rng(10,12),
              '0, rng(13,13), rng(1,12)};
    tv[2] = '{8'd0, 16'd3, 16'd1, 16'd4,
              '0, '0, '0, rng(1,1), '0};
    tv[3] = '{8'd1, 16'd0, 16'd0, 16'd0,
              rng(1,1), rng(2,2), '0, rng(3,3), rng(1,2)};
    tv[4] = '{8'd3, 16'd0, 16'd1, 16'd2,
              rng(1,1) | rng(5,5) | rng(9,9),
              rng(3,3) | rng(7,7) | rng(11,11),
              DAMP_ON ? rng(12,13) : '0,
              DAMP_ON ? rng(14,14) : rng(12,12),
              DAMP_ON ? rng(1,13) : rng(1,11)};
    tv[5] = '{8'd1, 16'd2, 16'd2, 16'd0,
              rng(1,2), rng(5,6), '0, rng(7,7), rng(1,6)};

    rst = 1'b1; pll_locked = 1'b0; start = 1'b0;
    num_pulses = '0; half_period = '0; dead_time = '0; damp_len = '0;
    repeat (3) cyc();
    chk("reset_outs", {tx_p, tx_n, damp, ready, busy, done, lock_err}, 7'b0);
    rst = 1'b0;
    repeat (2) cyc();

    // Lock-up with an early start that must be ignored.
    num_pulses = 8'd1; half_period = 16'd1;
    pll_locked = 1'b1;
    wait_ready(5, k, sb);
    chk("lockup_latency", k, LS + 2);
    chk("early_start_busy", sb, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_burst(tv[i], -1, -1, gp, gn, gd, gdn, gb);
      chk($sformatf("v%0d_txp", i), gp, tv[i].p);
      chk($sformatf("v%0d_txn", i), gn, tv[i].n);
      chk($sformatf("v%0d_damp", i), gd, tv[i].d);
      chk($sformatf("v%0d_done", i), gdn, tv[i].dn);
      chk($sformatf("v%0d_busy", i), gb, tv[i].bz);
      chk($sformatf("v%0d_lerr", i), lock_err, 1'b0);
    end

    // Starts while busy and in the FIN cycle are both ignored.
    dcyc = DAMP_ON ? 20 : 16;
    run_burst(tv[0], 5, dcyc, gp, gn, gd, gdn, gb);
    chk("busy_start_txp", gp, tv[0].p);
    chk("busy_start_txn", gn, tv[0].n);
    chk("busy_start_done", gdn, tv[0].dn);
    chk("busy_start_busy", gb, tv[0].bz);

    // Lock loss during NEG of a P=4,H=5,D=1 burst.
    num_pulses = 8'd4; half_period = 16'd5; dead_time = 16'd1; damp_len = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    chk("loss_pre_txn", tx_n, 1'b1);
    pll_locked = 1'b0;
    cyc();
    chk("loss_c9_txn", tx_n, 1'b1);
    cyc();
    chk("loss_c10_txn", tx_n, 1'b1);
    cyc();
    chk("loss_drive", {tx_p, tx_n, damp, busy}, 4'b0);
    chk("loss_done", done, 1'b1);
    chk("loss_lerr", lock_err, 1'b1);
    chk("loss_ready", ready, 1'b0);
    cyc();
    chk("loss_done_clr", done, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("unlocked_start_busy", busy, 1'b0);
    chk("lerr_sticky", lock_err, 1'b1);
    pll_locked = 1'b1;
    wait_ready(-1, k, sb);
    chk("relock_latency", k, LS + 2);
    chk("lerr_after_relock", lock_err, 1'b1);
    num_pulses = 8'd1; half_period = 16'd1; dead_time = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("lerr_cleared", lock_err, 1'b0);
    chk("restart_txp", {tx_p, busy}, 2'b11);
    repeat (5) cyc();

    // Reset during POS, then full requalification.
    num_pulses = 8'd2; half_period = 16'd3; dead_time = 16'd1; damp_len = 16'd4;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("pre_rst_txp", tx_p, 1'b1);
    rst = 1'b1;
    cyc();
    chk("midrst_outs", {tx_p, tx_n, damp, ready, busy, done, lock_err}, 7'b0);
    cyc();
    rst = 1'b0;
    wait_ready(-1, k, sb);
    chk("rst_requal", k, LS + 2);
    chk("rst_requal_busy", sb, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
